call_stack: RTL and testbench
=============================

// Module: call_stack
// PURPOSE
//   Hardware return-address stack feeding the program counter's return path.
//   On a call it pushes the return address (PC+1, supplied by core).
//   On a return it presents the top entry on DoST and pops it.
//   Sits beside the PC; the control decoder drives Call/Ret from the opcode.
// PARAMETERS
//   AW     16  address width (matches PC width)
//   DEPTH  16  number of entries; power of two, >=2
// PORTS
//   CLK     in   1         clock; all state updates on negedge CLK (same edge as PC)
//   RST_N   in   1         asynchronous reset, active low
//   Call    in   1         push ADDRin this edge
//   Ret     in   1         pop top this edge; DoST valid during the cycle
//   ClrErr  in   1         clear sticky Ovf/Udf
//   ADDRin  in   AW        return address to push
//   DoST    out  AW        current top entry (combinational read of stored top); 0 when empty
//   Count   out  CW        occupancy 0..DEPTH, CW=$clog2(DEPTH+1)
//   Full    out  1         Count==DEPTH
//   Empty   out  1         Count==0
//   Ovf     out  1         sticky: push attempted while full
//   Udf     out  1         sticky: pop attempted while empty
// BEHAVIOUR
//   - Reset (RST_N low, async): Count=0, top pointer=0, Ovf=Udf=0, DoST=0.
//     Entry storage not reset. Reset mid-call/return discards the operation.
//   - Storage: circular array, top pointer tp (log2 DEPTH bits, wraps mod DEPTH).
//     DoST = Empty ? 0 : mem[tp]. Zero-latency read; the PC samples DoST on
//     the same negedge the pop takes effect.
//   - Push only (Call & !Ret), not full: tp<=tp+1, mem[tp+1]<=ADDRin, Count++.
//   - Pop only (Ret & !Call), not empty: tp<=tp-1, Count--.
//   - Call & Ret together, not empty: replace top: mem[tp]<=ADDRin;
//     tp and Count unchanged. DoST shows the old top this cycle, the new one after.
//   - Call & Ret together, empty: Udf<=1; push proceeds (Count=1, top=ADDRin).
//   - Pop while empty: no state change, Udf<=1, DoST stays 0.
//   - Push while full: see CONFIGURATION; Ovf<=1 in all builds.
//   - ClrErr: Ovf<=0, Udf<=0 this edge. A new error in the same edge wins (flag set).
//   - Full/Empty/Count derive from Count only; no separate state machine.
//     Count saturates at DEPTH.
//   - Arithmetic: tp modulo DEPTH (natural wrap); ADDRin stored verbatim, no add.
// CONFIGURATION
//   CALL_STACK_WRAP_EN defined: push while full overwrites the oldest entry;
//     tp<=tp+1, mem[tp+1]<=ADDRin, Count stays DEPTH (deep recursion keeps
//     newest DEPTH returns).
//   CALL_STACK_WRAP_EN undefined: push while full is dropped; tp, mem, Count
//     unchanged.
// STRUCTURE
//   call_stack_pkg: AW default, DEPTH default, CW function/localparam,
//     reset value constant for DoST (16'h0000).
//   Sub-module stack_regfile: DEPTH x AW, one negedge write port, one async
//     read port. call_stack keeps tp/Count/flag logic.
// TESTING
//   1 Reset, no ops -> Empty=1, Count=0, DoST=0, Ovf=Udf=0.
//   2 Push 0x0011, 0x0022, 0x0033 -> Count=3, DoST=0x0033; Ret x3 -> DoST
//     0x0033, 0x0022, 0x0011 on successive cycles; then Empty=1, DoST=0.
//   3 Ret while empty -> Udf=1, Count=0; ClrErr -> Udf=0.
//   4 Push 0x0100, then Call&Ret with ADDRin=0x0200 -> Count=1, DoST=0x0200
//     next cycle.
//   5 Push DEPTH+1 values 1..17 (DEPTH=16) -> Ovf=1, Count=16; WRAP_EN off:
//     DoST=16, pops yield 16..1; WRAP_EN on: DoST=17, pops yield 17..2.
//   6 Pull RST_N low between negedges after 3 pushes -> Count=0, DoST=0
//     immediately, no clock needed.

Source files
------------

// File: rtl/call_stack_pkg.sv
// Shared defaults and helpers for the hardware return-address stack.
// The build option CALL_STACK_WRAP_EN is consumed in call_stack.sv.
package call_stack_pkg;

    localparam int AW_DEF    = 16;
    localparam int DEPTH_DEF = 16;

    localparam logic [15:0] DOST_RST = 16'h0000;

    // Occupancy needs to represent 0..DEPTH inclusive.
    function automatic int cw_f(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_regfile.sv
// Return-address storage: DEPTH x AW, one negedge write port, one async read port.
// Contents are intentionally not reset.
module stack_regfile #(
    parameter int   AW    = 16,
    parameter int   DEPTH = 16,
    localparam int  PW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  logic [AW-1:0] wdata_i,
    input  logic [PW-1:0] raddr_i,
    output logic [AW-1:0] rdata_o
);

    logic [AW-1:0] mem_q [DEPTH];

    always_ff @(negedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// Return-address stack beside the PC; all state moves on negedge CLK.
// Define CALL_STACK_WRAP_EN to let a push while full overwrite the oldest entry.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int  AW    = AW_DEF,
    parameter int  DEPTH = DEPTH_DEF,
    localparam int CW    = cw_f(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          Call,
    input  logic          Ret,
    input  logic          ClrErr,
    input  logic [AW-1:0] ADDRin,
    output logic [AW-1:0] DoST,
    output logic [CW-1:0] Count,
    output logic          Full,
    output logic          Empty,
    output logic          Ovf,
    output logic          Udf
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [PW-1:0] tp_q, tp_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          we;
    logic [PW-1:0] waddr;
    logic [AW-1:0] rdata;
    logic          full, empty;

    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);

    always_comb begin
        tp_d    = tp_q;
        count_d = count_q;
        we      = 1'b0;
        waddr   = tp_q + PW'(1);
        // Clear first so an error raised on the same edge wins.
        ovf_d   = ClrErr ? 1'b0 : ovf_q;
        udf_d   = ClrErr ? 1'b0 : udf_q;

        if (Call && Ret) begin
            if (!empty) begin
                we    = 1'b1;
                waddr = tp_q;
            end else begin
                udf_d   = 1'b1;
                we      = 1'b1;
                tp_d    = tp_q + PW'(1);
                count_d = CW'(1);
            end
        end else if (Call) begin
            if (!full) begin
                we      = 1'b1;
                tp_d    = tp_q + PW'(1);
                count_d = count_q + CW'(1);
            end else begin
                ovf_d = 1'b1;
`ifdef CALL_STACK_WRAP_EN
                we    = 1'b1;
                tp_d  = tp_q + PW'(1);
`endif
            end
        end else if (Ret) begin
            if (!empty) begin
                tp_d    = tp_q - PW'(1);
                count_d = count_q - CW'(1);
            end else begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            tp_q    <= tp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    stack_regfile #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk_i   (CLK),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (ADDRin),
        .raddr_i (tp_q),
        .rdata_o (rdata)
    );

    assign DoST  = empty ? AW'(DOST_RST) : rdata;
    assign Count = count_q;
    assign Full  = full;
    assign Empty = empty;
    assign Ovf   = ovf_q;
    assign Udf   = udf_q;

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: table vectors plus a reference-stack scoreboard.
module tb_call_stack;

    localparam int AW    = 16;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          Call = 1'b0;
    logic          Ret = 1'b0;
    logic          ClrErr = 1'b0;
    logic [AW-1:0] ADDRin = '0;
    logic [AW-1:0] DoST;
    logic [CW-1:0] Count;
    logic          Full, Empty, Ovf, Udf;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] pre_dost;

    call_stack dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .Call   (Call),
        .Ret    (Ret),
        .ClrErr (ClrErr),
        .ADDRin (ADDRin),
        .DoST   (DoST),
        .Count  (Count),
        .Full   (Full),
        .Empty  (Empty),
        .Ovf    (Ovf),
        .Udf    (Udf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          call;
        logic          ret;
        logic          clr;
        logic [AW-1:0] addr;
        int            exp_count;
        logic [AW-1:0] exp_dost;
        logic          exp_ovf;
        logic          exp_udf;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Apply one cycle: drive after posedge, sample DoST before the negedge,
    // let the negedge commit, then leave time for post-edge sampling.
    task automatic step(input logic c, input logic r, input logic clr, input logic [AW-1:0] a);
        @(posedge CLK);
        #1;
        Call = c; Ret = r; ClrErr = clr; ADDRin = a;
        #1;
        pre_dost = DoST;
        @(negedge CLK);
        #1;
        Call = 1'b0; Ret = 1'b0; ClrErr = 1'b0;
    endtask

    // Reference stack: expected tops pushed on call, popped and compared on return.
    task automatic model_step(input logic c, input logic r, input logic [AW-1:0] a);
        logic [AW-1:0] e;
        if (c && r) begin
            if (exp_q.size() == 0) begin
                check("dost_pre_callret_empty", int'(pre_dost), 0);
            end else begin
                e = exp_q.pop_back();
                check("dost_pre_replace", int'(pre_dost), int'(e));
            end
            exp_q.push_back(a);
        end else if (c) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(a);
            end else begin
`ifdef CALL_STACK_WRAP_EN
                void'(exp_q.pop_front());
                exp_q.push_back(a);
`endif
            end
        end else if (r) begin
            if (exp_q.size() == 0) begin
                check("dost_pre_pop_empty", int'(pre_dost), 0);
            end else begin
                e = exp_q.pop_back();
                check("dost_pre_pop", int'(pre_dost), int'(e));
            end
        end
    endtask

    task automatic check_model_state(input string tag);
        check({tag, "_count"}, int'(Count), exp_q.size());
        check({tag, "_dost"}, int'(DoST), (exp_q.size() == 0) ? 0 : int'(exp_q[$]));
        check({tag, "_empty"}, int'(Empty), int'(exp_q.size() == 0));
        check({tag, "_full"}, int'(Full), int'(exp_q.size() == DEPTH));
    endtask

    task automatic do_op(input logic c, input logic r, input logic clr, input logic [AW-1:0] a);
        step(c, r, clr, a);
        model_step(c, r, a);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0011, 1, 16'h0011, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0022, 2, 16'h0022, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0033, 3, 16'h0033, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 2, 16'h0022, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, 16'h0011, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h0000, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0100, 1, 16'h0100, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0200, 1, 16'h0200, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 16'h0300, 1, 16'h0300, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 16'h0000, 0, 16'h0000, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 16'h0000, 0, 16'h0000, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h0000, 1'b0, 1'b0};

        // Reset state.
        #12;
        check("rst_count", int'(Count), 0);
        check("rst_dost", int'(DoST), 0);
        check("rst_empty", int'(Empty), 1);
        check("rst_ovf", int'(Ovf), 0);
        check("rst_udf", int'(Udf), 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Table: push/pop ordering, underflow, clear, replace, error-wins-over-clear.
        for (int i = 0; i < 15; i++) begin
            do_op(vecs[i].call, vecs[i].ret, vecs[i].clr, vecs[i].addr);
            check($sformatf("vec%0d_count", i), int'(Count), vecs[i].exp_count);
            check($sformatf("vec%0d_dost", i), int'(DoST), int'(vecs[i].exp_dost));
            check($sformatf("vec%0d_ovf", i), int'(Ovf), int'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_udf", i), int'(Udf), int'(vecs[i].exp_udf));
            check_model_state($sformatf("vec%0d_model", i));
        end

        // Overflow: push 1..DEPTH+1.
        for (int v = 1; v <= DEPTH + 1; v++) begin
            do_op(1'b1, 1'b0, 1'b0, AW'(v));
        end
        check("ovf_flag", int'(Ovf), 1);
        check("ovf_count", int'(Count), DEPTH);
        check("ovf_full", int'(Full), 1);
`ifdef CALL_STACK_WRAP_EN
        check("ovf_top", int'(DoST), DEPTH + 1);
`else
        check("ovf_top", int'(DoST), DEPTH);
`endif
        check_model_state("ovf_model");
        for (int i = 0; i < DEPTH; i++) begin
            do_op(1'b0, 1'b1, 1'b0, '0);
        end
        check_model_state("drain");
        check("drain_empty", int'(Empty), 1);
        do_op(1'b0, 1'b0, 1'b1, '0);
        check("ovf_cleared", int'(Ovf), 0);
        check("udf_after_drain", int'(Udf), 0);

        // Random mixed traffic against the reference stack.
        for (int i = 0; i < 60; i++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                  AW'($urandom_range(0, 16'hffff)));
            check_model_state($sformatf("rnd%0d", i));
        end

        // Async reset between negedges after three pushes.
        do_op(1'b0, 1'b0, 1'b1, '0);
        while (exp_q.size() != 0) do_op(1'b0, 1'b1, 1'b0, '0);
        do_op(1'b1, 1'b0, 1'b0, 16'h0aaa);
        do_op(1'b1, 1'b0, 1'b0, 16'h0bbb);
        do_op(1'b1, 1'b0, 1'b0, 16'h0ccc);
        check("pre_rst_count", int'(Count), 3);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("arst_count", int'(Count), 0);
        check("arst_dost", int'(DoST), 0);
        check("arst_empty", int'(Empty), 1);
        exp_q.delete();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        do_op(1'b1, 1'b0, 1'b0, 16'h1234);
        check_model_state("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no end of test, expected finish before 50000");
        $fatal(1);
    end

endmodule
